// File: rtl/instruction_fetch_pkg.sv
// Shared core definitions for the fetch stage: FSM encoding, default
// reset vector and halt word, and the word-alignment helper.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0010_0073;  // EBREAK

  // Force a byte address onto a 4-byte boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch: drives the instruction memory address
// straight from the PC, registers the returned word for decode, and
// sequences BOOT -> RUN -> HALT, with redirect able to leave any state.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        misaligned_o,
  output logic        halted_o
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_o;
  logic        r_valid;
  logic        r_misaligned;

  logic        w_is_halt;
  logic        w_capture;
  logic        w_pc_advance;
  logic        w_drop_valid;

  assign w_is_halt = (imem_instr == HALT_INSTR);

  // State register: reset lands in BOOT.
  // NOTE: every always_ff uses non-blocking (<=) so all registers sample
  // the same pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  // Next-state: redirect wins over stall and every state; stall freezes.
  // NOTE: the default assignment at the top keeps this purely combinational;
  // leaving a path without an assignment would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = ST_RUN;
    end else if (!stall) begin
      case (r_state)
        ST_BOOT: w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = w_is_halt ? ST_HALT : ST_RUN;
        ST_HALT: w_state_nxt = ST_HALT;
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  // Output/control decode from the current state and the hold/redirect inputs.
  always_comb begin
    w_capture    = (r_state == ST_RUN) && !redirect && !stall;
    w_pc_advance = w_capture && !w_is_halt;
    w_drop_valid = redirect || ((r_state == ST_HALT) && !stall);
    halted_o     = (r_state == ST_HALT);
  end

  // Datapath: PC, decode-facing output registers and the misalignment pulse.
  // NOTE: the output registers are reset explicitly so a stalled word is
  // discarded cleanly; there is no memory array here that would need
  // to be left un-reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_pc_o       <= '0;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= redirect && (redirect_pc[1:0] != 2'b00);

      if (redirect)          r_pc <= align_word(redirect_pc);
      else if (w_pc_advance) r_pc <= r_pc + 32'd4;

      if (w_capture) begin
        r_instr <= imem_instr;
        r_pc_o  <= r_pc;
      end

      if (w_capture)         r_valid <= 1'b1;
      else if (w_drop_valid) r_valid <= 1'b0;
    end
  end

  assign imem_addr    = r_pc;
  assign instr_o      = r_instr;
  assign pc_o         = r_pc_o;
  assign valid_o      = r_valid;
  assign misaligned_o = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table,
// hand-written halt / reset corner sequences, and a randomized run
// compared against a behavioural model of the fetch rules.
module tb_instruction_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        misaligned_o;
  logic        halted_o;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[9:2]];

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .valid_o     (valid_o),
    .misaligned_o(misaligned_o),
    .halted_o    (halted_o)
  );

  // ---------------- behavioural reference model ----------------
  // mode: 0 = waiting one cycle after reset, 1 = fetching, 2 = stopped
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc_o;
  logic        m_valid, m_mis;

  task automatic model_edge();
    logic [31:0] w;
    if (rst) begin
      m_pc = 32'h0; m_instr = 0; m_pc_o = 0; m_valid = 0; m_mis = 0; m_mode = 0;
    end else if (redirect) begin
      m_pc    = redirect_pc - (redirect_pc % 4);
      m_valid = 0;
      m_mis   = (redirect_pc % 4) != 0;
      m_mode  = 1;
    end else begin
      m_mis = 0;
      if (!stall) begin
        if (m_mode == 0) begin
          m_mode = 1;
        end else if (m_mode == 1) begin
          w       = mem[m_pc[9:2]];
          m_instr = w;
          m_pc_o  = m_pc;
          m_valid = 1;
          if (w == HALT) m_mode = 2;
          else           m_pc = m_pc + 4;
        end else begin
          m_valid = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic mis, input logic hlt,
                         input logic [31:0] addr);
    check({tag, " valid_o"},      32'(valid_o),      32'(v));
    check({tag, " pc_o"},         pc_o,              pc);
    check({tag, " instr_o"},      instr_o,           ins);
    check({tag, " misaligned_o"}, 32'(misaligned_o), 32'(mis));
    check({tag, " halted_o"},     32'(halted_o),     32'(hlt));
    check({tag, " imem_addr"},    imem_addr,         addr);
  endtask

  // Advance one rising edge with the currently driven inputs; sample #1 later.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rp);
    rst = r; stall = s; redirect = rd; redirect_pc = rp;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, stall, redirect;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc, instr;
    logic        mis, halted;
    logic [31:0] addr;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] rp, logic v,
                              logic [31:0] pc, logic [31:0] ins, logic mis,
                              logic [31:0] addr);
    vec_t t;
    t.rst = r; t.stall = s; t.redirect = rd; t.rpc = rp; t.valid = v;
    t.pc = pc; t.instr = ins; t.mis = mis; t.halted = 1'b0; t.addr = addr;
    return t;
  endfunction

  vec_t tbl [17];

  initial begin
    drive(1, 0, 0, 0);
    for (int i = 0; i < 256; i++) mem[i] = NOP;

    //            rst stl red rpc           v  pc_o          instr mis addr
    tbl[0]  = mk(1, 0, 0, 32'h0,          0, 32'h0,        0,   0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,          0, 32'h0,        0,   0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,          1, 32'h0,        NOP, 0, 32'h4);
    tbl[3]  = mk(0, 0, 0, 32'h0,          1, 32'h4,        NOP, 0, 32'h8);
    tbl[4]  = mk(0, 0, 0, 32'h0,          1, 32'h8,        NOP, 0, 32'hC);
    tbl[5]  = mk(0, 1, 0, 32'h0,          1, 32'h8,        NOP, 0, 32'hC);
    tbl[6]  = mk(0, 1, 0, 32'h0,          1, 32'h8,        NOP, 0, 32'hC);
    tbl[7]  = mk(0, 1, 0, 32'h0,          1, 32'h8,        NOP, 0, 32'hC);
    tbl[8]  = mk(0, 0, 0, 32'h0,          1, 32'hC,        NOP, 0, 32'h10);
    tbl[9]  = mk(0, 1, 1, 32'h20,         0, 32'hC,        NOP, 0, 32'h20);
    tbl[10] = mk(0, 0, 0, 32'h0,          1, 32'h20,       NOP, 0, 32'h24);
    tbl[11] = mk(0, 0, 1, 32'h23,         0, 32'h20,       NOP, 1, 32'h20);
    tbl[12] = mk(0, 0, 0, 32'h0,          1, 32'h20,       NOP, 0, 32'h24);
    tbl[13] = mk(0, 0, 0, 32'h0,          1, 32'h24,       NOP, 0, 32'h28);
    tbl[14] = mk(0, 0, 1, 32'hFFFF_FFFC,  0, 32'h24,       NOP, 0, 32'hFFFF_FFFC);
    tbl[15] = mk(0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, NOP, 0, 32'h0);
    tbl[16] = mk(0, 0, 0, 32'h0,          1, 32'h0,        NOP, 0, 32'h4);

    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].redirect, tbl[i].rpc);
      step();
      chk_out($sformatf("row%0d", i), tbl[i].valid, tbl[i].pc, tbl[i].instr,
              tbl[i].mis, tbl[i].halted, tbl[i].addr);
    end

    // ---------------- halt sequence ----------------
    mem[4] = HALT;
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0); step();
    for (int i = 0; i < 4; i++) step();
    step();
    chk_out("halt_deliver", 1, 32'h10, HALT, 0, 1, 32'h10);
    drive(0, 1, 0, 0); step();
    chk_out("halt_stall",   1, 32'h10, HALT, 0, 1, 32'h10);
    drive(0, 0, 0, 0); step();
    chk_out("halt_idle1",   0, 32'h10, HALT, 0, 1, 32'h10);
    step();
    chk_out("halt_idle2",   0, 32'h10, HALT, 0, 1, 32'h10);
    drive(0, 0, 1, 32'h0); step();
    chk_out("halt_redir",   0, 32'h10, HALT, 0, 0, 32'h0);
    drive(0, 0, 0, 0); step();
    chk_out("halt_resume",  1, 32'h0,  NOP,  0, 0, 32'h4);

    // ---------------- reset while stalled ----------------
    mem[4] = NOP;
    drive(1, 0, 0, 0); step();
    drive(0, 0, 0, 0); step();
    for (int i = 0; i < 6; i++) step();
    chk_out("rst_pre",     1, 32'h14, NOP, 0, 0, 32'h18);
    drive(0, 1, 0, 0); step();
    chk_out("rst_stalled", 1, 32'h14, NOP, 0, 0, 32'h18);
    drive(1, 1, 1, 32'h40); step();
    chk_out("rst_hit",     0, 32'h0,  0,   0, 0, 32'h0);
    drive(0, 0, 0, 0); step();
    chk_out("rst_boot",    0, 32'h0,  0,   0, 0, 32'h0);
    step();
    chk_out("rst_first",   1, 32'h0,  NOP, 0, 0, 32'h4);

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? HALT : $urandom;
    drive(1, 0, 0, 0); step();
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0,
            $urandom);
      step();
      chk_out($sformatf("rand%0d", c), m_valid, m_pc_o, m_instr, m_mis,
              m_mode == 2, m_pc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: the PC value loaded on reset.
REQ-002 The block SHALL have parameter HALT_INSTR, default 32'h0010_0073 (EBREAK): the instruction word that stops fetch.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port imem_addr, output, 32 bits: byte address to the instruction memory Addr input.
REQ-006 Port imem_instr, input, 32 bits: little-endian word returned combinationally by the instruction memory for imem_addr.
REQ-007 Port stall, input, 1 bit: the downstream decode stage cannot accept; hold.
REQ-008 Port redirect, input, 1 bit: branch/jump taken; load a new PC.
REQ-009 Port redirect_pc, input, 32 bits: redirect target byte address.
REQ-010 Port instr_o, output, 32 bits: registered instruction to decode.
REQ-011 Port pc_o, output, 32 bits: registered address of instr_o.
REQ-012 Port valid_o, output, 1 bit: instr_o/pc_o hold a real instruction.
REQ-013 Port misaligned_o, output, 1 bit: one-cycle pulse, the last redirect target had nonzero bits [1:0].
REQ-014 Port halted_o, output, 1 bit: high while the FSM is in HALT.

Function
REQ-015 imem_addr SHALL equal the internal PC register combinationally; the block adds no cycle to memory latency.
REQ-016 The FSM SHALL have states BOOT, RUN, HALT; reset enters BOOT; BOOT -> RUN unconditionally after one cycle with valid_o=0 and PC unchanged.
REQ-017 In RUN with redirect=0 and stall=0, on the edge: instr_o<=imem_instr, pc_o<=PC, valid_o<=1, PC<=PC+4 (modulo 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-018 In RUN, if the captured imem_instr equals HALT_INSTR, it SHALL be delivered with valid_o=1, PC SHALL NOT increment, and the FSM SHALL go to HALT.
REQ-019 With stall=1 and redirect=0, PC, instr_o, pc_o, valid_o and FSM state SHALL hold unchanged in every state.
REQ-020 redirect=1 SHALL take priority over stall and over all FSM states: PC<=redirect_pc with bits [1:0] cleared, valid_o<=0 (bubble), FSM<=RUN.
REQ-021 misaligned_o SHALL be 1 for exactly the cycle after a redirect whose redirect_pc[1:0]!=0, and 0 otherwise.
REQ-022 In HALT with stall=0 and redirect=0, valid_o SHALL go to 0 and PC SHALL hold; the FSM stays in HALT.
REQ-023 First valid instruction: valid_o=1 after the second rising edge following reset release, carrying the word at RESET_PC.

Reset
REQ-024 While rst=1 on an edge: PC<=RESET_PC, instr_o<=0, pc_o<=0, valid_o<=0, misaligned_o<=0, FSM<=BOOT; rst overrides redirect and stall.
REQ-025 Reset asserted mid-stream SHALL discard any held instruction with no partial update.

Structure
REQ-026 FSM state encodings, the default RESET_PC and HALT_INSTR constants SHALL live in the shared core package.
REQ-027 The block SHALL be a single module with no sub-modules; the instruction memory is instantiated alongside it at top level, not inside.

Verification
REQ-028 Reset, memory with 0x00000013 at 0..60 -> valid_o rises on the 2nd edge, pc_o steps 0,4,8,... with instr_o=0x00000013.
REQ-029 stall held 3 cycles at pc_o=8 -> pc_o=8, instr_o, valid_o unchanged for 3 cycles; next edge pc_o=12.
REQ-030 redirect=1, redirect_pc=0x20 together with stall=1 -> next cycle valid_o=0, misaligned_o=0; following edge pc_o=0x20.
REQ-031 redirect_pc=0x23 -> misaligned_o=1 for one cycle, next delivered pc_o=0x20.
REQ-032 0x00100073 at address 0x10 -> delivered with valid_o=1, halted_o=1, then valid_o=0 and imem_addr stays 0x10; redirect to 0 resumes at pc_o=0.
REQ-033 rst asserted while stalled at pc_o=0x14 -> valid_o=0, imem_addr=RESET_PC next cycle.
